// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: binary/Gray write pointers, 2-flop sync of the
// read-domain Gray pointer, and full / almost-full / level / sticky-overflow status.
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 2
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr,
    input  logic              wovf_clr,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic              wfull,
    output logic              walmost,
    output logic [ADDR_W:0]   wlevel,
    output logic              wovf
);

    localparam int              PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** ADDR_W);
    localparam logic [PTR_W-1:0] AF    = PTR_W'(AF_THRESH);

    logic [PTR_W-1:0] wbin_reg;
    logic [PTR_W-1:0] wptr_reg;
    logic [PTR_W-1:0] rq1_reg;
    logic [PTR_W-1:0] rq2_reg;
    logic [PTR_W-1:0] wlevel_reg;
    logic             wfull_reg;
    logic             walmost_reg;
    logic             wovf_reg;

    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin_sync;
    logic [PTR_W-1:0] level_next;
    logic [PTR_W-1:0] free_next;
    logic             full_next;
    logic             almost_next;
    logic             ovf_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PTR_W; gi++) begin : g_gray2bin
            assign rbin_sync[gi] = ^rq2_reg[PTR_W-1:gi];
        end
    endgenerate

    always_comb begin
        wen         = winc & ~wfull_reg;
        wbin_next   = wbin_reg + PTR_W'(wen);
        wgray_next  = (wbin_next >> 1) ^ wbin_next;
        // Full when the next write pointer has lapped the synced read pointer exactly once.
        full_next   = (wgray_next == {~rq2_reg[ADDR_W:ADDR_W-1], rq2_reg[ADDR_W-2:0]});
        level_next  = wbin_next - rbin_sync;
        free_next   = DEPTH - level_next;
        almost_next = (free_next <= AF);
        ovf_next    = wovf_reg;
        if (winc & wfull_reg) begin
            ovf_next = 1'b1;
        end else if (wovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_reg    <= '0;
            wptr_reg    <= '0;
            rq1_reg     <= '0;
            rq2_reg     <= '0;
            wlevel_reg  <= '0;
            wfull_reg   <= 1'b0;
            walmost_reg <= 1'b0;
            wovf_reg    <= 1'b0;
        end else begin
            rq1_reg     <= rptr;
            rq2_reg     <= rq1_reg;
            wbin_reg    <= wbin_next;
            wptr_reg    <= wgray_next;
            wlevel_reg  <= level_next;
            wfull_reg   <= full_next;
            walmost_reg <= almost_next;
            wovf_reg    <= ovf_next;
        end
    end

    assign wptr    = wptr_reg;
    assign waddr   = wbin_reg[ADDR_W-1:0];
    assign wfull   = wfull_reg;
    assign walmost = walmost_reg;
    assign wlevel  = wlevel_reg;
    assign wovf    = wovf_reg;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed and random pushes/reads checked against a
// counting model (total writes, total reads, reads seen two edges late).
module tb_fifo_wr_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              wclk = 1'b0;
    logic              wrst = 1'b1;
    logic              winc = 1'b0;
    logic [ADDR_W:0]   rptr = '0;
    logic              wovf_clr = 1'b0;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W-1:0] waddr;
    logic              wen;
    logic              wfull;
    logic              walmost;
    logic [ADDR_W:0]   wlevel;
    logic              wovf;

    fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(2)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr), .wovf_clr(wovf_clr),
        .wptr(wptr), .waddr(waddr), .wen(wen), .wfull(wfull), .walmost(walmost),
        .wlevel(wlevel), .wovf(wovf)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain counts of accepted writes and reads; the write side
    // sees the read count that was on rptr two edges earlier.
    int writes   = 0;
    int rd_count = 0;
    int hist[$];
    bit full_m   = 0;
    bit almost_m = 0;
    bit ovf_m    = 0;
    int level_m  = 0;

    function automatic int gray(input int v);
        int m;
        m = v % (2 * DEPTH);
        return (m >> 1) ^ m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        writes = 0; rd_count = 0; full_m = 0; almost_m = 0; ovf_m = 0; level_m = 0;
        hist = {};
        hist.push_back(0);
        hist.push_back(0);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_wptr"},    wptr,    gray(writes));
        chk({tag, "_waddr"},   waddr,   writes % DEPTH);
        chk({tag, "_wfull"},   wfull,   full_m);
        chk({tag, "_walmost"}, walmost, almost_m);
        chk({tag, "_wlevel"},  wlevel,  level_m);
        chk({tag, "_wovf"},    wovf,    ovf_m);
    endtask

    task automatic do_cycle(input bit w, input bit clr, input string tag, input bit verbose);
        bit wen_m;
        int seen;
        winc     = w;
        wovf_clr = clr;
        rptr     = (ADDR_W+1)'(gray(rd_count));
        #1;
        wen_m = w && !full_m;
        chk({tag, "_wen"}, wen, wen_m);
        @(posedge wclk);
        if (w && full_m) ovf_m = 1;
        else if (clr) ovf_m = 0;
        writes += int'(wen_m);
        seen = hist.pop_front();
        hist.push_back(rd_count);
        level_m  = writes - seen;
        full_m   = (level_m == DEPTH);
        almost_m = ((DEPTH - level_m) <= 2);
        #1;
        chk_outputs(tag);
        chk({tag, "_pessimistic"}, 32'(int'(wlevel) >= (writes - rd_count)), 1);
        if (verbose)
            $display("%s: winc=%0b clr=%0b rd=%0d wptr=%02h waddr=%0d wfull=%0b walmost=%0b wlevel=%0d wovf=%0b",
                     tag, w, clr, rd_count, wptr, waddr, wfull, walmost, wlevel, wovf);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        chk_outputs("reset");
        wrst = 1'b0;

        // Mid-stream reset with wbin=7: outputs clear before the next edge.
        for (int i = 0; i < 7; i++) do_cycle(1, 0, "pre_rst", 0);
        chk("pre_rst_waddr7", waddr, 7);
        #2 wrst = 1'b1;
        model_reset();
        #1;
        chk_outputs("async_rst");
        $display("async_rst: wptr=%02h waddr=%0d wlevel=%0d wovf=%0b", wptr, waddr, wlevel, wovf);
        @(negedge wclk);
        wrst = 1'b0;

        // Fill from empty.
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(1, 0, $sformatf("fill%0d", i), 1);
            if (i == 14) chk("fill14_walmost", walmost, 1);
        end
        chk("fill16_wfull", wfull, 1);
        chk("fill16_wlevel", wlevel, 16);

        // Overflow and clear priority.
        do_cycle(1, 0, "ovf_push", 1);
        chk("ovf_set", wovf, 1);
        chk("ovf_wptr_hold", wptr, gray(16));
        do_cycle(1, 1, "ovf_set_wins", 1);
        chk("ovf_set_wins_flag", wovf, 1);
        do_cycle(0, 1, "ovf_clr", 1);
        chk("ovf_cleared", wovf, 0);

        // Release latency: one read frees a slot, seen on the 3rd edge.
        rd_count = 1;
        do_cycle(0, 0, "rel_e1", 1);
        chk("rel_e1_full", wfull, 1);
        do_cycle(0, 0, "rel_e2", 1);
        chk("rel_e2_full", wfull, 1);
        do_cycle(0, 0, "rel_e3", 1);
        chk("rel_e3_full", wfull, 0);
        chk("rel_e3_level", wlevel, 15);

        // Wrap with the reader trailing two entries behind.
        @(negedge wclk);
        wrst = 1'b1;
        model_reset();
        @(negedge wclk);
        wrst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd_count = (writes >= 2) ? writes - 2 : 0;
            do_cycle(1, 0, $sformatf("wrap%0d", i), 1);
            chk("wrap_nofull", wfull, 0);
            chk("wrap_noovf", wovf, 0);
        end

        // Random pushes, reads and clears; first phase fill-heavy to sit at full.
        for (int i = 0; i < 1600; i++) begin
            bit w, c;
            if (rd_count < writes && ($urandom_range(0, (i < 600) ? 5 : 1) == 0))
                rd_count++;
            w = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0);
            do_cycle(w, c, $sformatf("rnd%0d", i), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
